// File: rtl/sodor_run_pkg.sv
// Shared types and defaults for the Sodor multi-core run controller.
// Holds the run FSM encoding, default halt word and reset-hold length, and the hold-counter width helper.
package sodor_run_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } run_state_e;

  localparam logic [31:0] SODOR_HALT_INSN  = 32'h8082;
  localparam int          SODOR_RESET_HOLD = 4;

  // Bits needed to hold the values 0..hold inclusive; never narrower than one bit.
  function automatic int hold_cnt_w(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/sodor_run_ctrl_if.sv
// Fuzz-harness side of the run controller: run control, injection, fetch snoop and status.
// The master drives start/injection/fetch data; the slave (controller) returns per-core reset and run status.
interface sodor_run_ctrl_if #(
  parameter int NUM_CORES = 2,
  parameter int XLEN      = 32,
  parameter int CNT_W     = 32
);

  logic                      start;
  logic [NUM_CORES-1:0]      inject_req;
  logic [NUM_CORES*XLEN-1:0] imem_resp_data;
  logic [NUM_CORES-1:0]      core_reset;
  logic [NUM_CORES-1:0]      core_halted;
  logic                      running;
  logic                      done;
  logic                      timeout;
  logic [CNT_W-1:0]          cycle_count;

  modport master (
    output start,
    output inject_req,
    output imem_resp_data,
    input  core_reset,
    input  core_halted,
    input  running,
    input  done,
    input  timeout,
    input  cycle_count
  );

  modport slave (
    input  start,
    input  inject_req,
    input  imem_resp_data,
    output core_reset,
    output core_halted,
    output running,
    output done,
    output timeout,
    output cycle_count
  );

endinterface

// File: rtl/sodor_reset_pulse.sv
// Per-core reset pulse: a load starts a busy window of exactly RESET_HOLD cycles beginning at the next edge.
// Loads arriving while busy are dropped so a pulse is never stretched; no backpressure.
module sodor_reset_pulse
  import sodor_run_pkg::*;
#(
  parameter int RESET_HOLD = SODOR_RESET_HOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);

  localparam int            CW       = hold_cnt_w(RESET_HOLD);
  localparam logic [CW-1:0] LOAD_VAL = CW'(RESET_HOLD);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else if (load) begin
      cnt_d = LOAD_VAL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/sodor_run_ctrl.sv
// Run controller for N Sodor cores: reset sequencing, reset injection, halt detection, cycle count and watchdog.
// Status is registered state (one-edge response); no backpressure. Optional SODOR_RUN_FINISH_EN: sim-only report + $finish.
module sodor_run_ctrl
  import sodor_run_pkg::*;
#(
  parameter int              NUM_CORES  = 2,
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] HALT_INSN  = XLEN'(SODOR_HALT_INSN),
  parameter int              RESET_HOLD = SODOR_RESET_HOLD,
  parameter int              TIMEOUT    = 100000,
  parameter int              CNT_W      = 32
) (
  input logic             clk,
  input logic             rst_n,
  sodor_run_ctrl_if.slave bus
);

  localparam int               RCW     = hold_cnt_w(RESET_HOLD);
  localparam logic [RCW-1:0]   RST_LD  = RCW'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  run_state_e           state_q, state_d;
  logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
  logic [NUM_CORES-1:0] halted_q, halted_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_CORES-1:0] hold_busy;
  logic [NUM_CORES-1:0] hold_load;
  logic [NUM_CORES-1:0] halt_match;
  logic [NUM_CORES-1:0] core_reset_int;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 wd_hit;
  logic                 in_run;

  assign in_run         = (state_q == RUN);
  assign core_reset_int = in_run ? (hold_busy | halted_q) : '1;

  // A core only counts as fetching while it is out of reset; a halt match outranks injection.
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    logic [XLEN-1:0] word;
    assign word = bus.imem_resp_data[i*XLEN +: XLEN];
`ifdef SODOR_RUN_FINISH_EN
    assign halt_match[i] = in_run && !core_reset_int[i] && (word === HALT_INSN);
`else
    assign halt_match[i] = in_run && !core_reset_int[i] && (word == HALT_INSN);
`endif
    assign hold_load[i]  = in_run && bus.inject_req[i] && !core_reset_int[i] && !halt_match[i];

    sodor_reset_pulse #(
      .RESET_HOLD (RESET_HOLD)
    ) u_pulse (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (hold_load[i]),
      .busy  (hold_busy[i])
    );
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  // Compare at 64 bits so a TIMEOUT beyond the counter range simply never fires.
  assign wd_hit  = (64'(cnt_inc) >= 64'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    halted_d  = halted_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d   = RESET;
          rst_cnt_d = RST_LD;
          halted_d  = '0;
          timeout_d = 1'b0;
          cnt_d     = '0;
        end
      end
      RESET: begin
        if (rst_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - RCW'(1);
        end
      end
      RUN: begin
        cnt_d    = cnt_inc;
        halted_d = halted_q | halt_match;
        if (&halted_d) begin
          state_d = DONE;
        end else if (wd_hit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rst_cnt_q <= '0;
      halted_q  <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.core_reset  = core_reset_int;
  assign bus.core_halted = halted_q;
  assign bus.running     = in_run;
  assign bus.done        = (state_q == DONE);
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cnt_q;

`ifdef SODOR_RUN_FINISH_EN
  // Report on the edge that closes the first DONE cycle, then end the simulation.
  always @(posedge clk) begin
    if (rst_n && state_q == DONE) begin
      $display("sodor_run_ctrl: cycle_count=%0d core_halted=%b timeout=%b", cnt_q, halted_q, timeout_q);
      $finish;
    end
  end
`endif

endmodule
